// File: rtl/mult_scheduler_pkg.sv
// Shared types and width helpers for the
// round-robin multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  function automatic int idw_f(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic int tw_f(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first
// valid index at or above ptr, with wrap.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    logic hit;
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    // upper segment [ptr, NREQ) first
    for (int j = 0; j < NREQ; j++) begin
      if (!hit && req[j] && j >= int'(ptr)) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!hit && req[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one iterative multiplier among
// NREQ requesters with a done watchdog.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N = 32,
  parameter int TIMEOUT = 128,
  localparam int IDW = idw_f(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*N-1:0]      rsp_p,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic                mul_done,
  input  logic [2*N-1:0]      mul_p,
  output logic                busy
);

  localparam int TW = tw_f(TIMEOUT);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, id_q, gidx;
  logic [NREQ-1:0]  grant;
  logic [N-1:0]     a_q, b_q, sel_a, sel_b;
  logic [2*N-1:0]   p_q;
  logic             err_q;
  logic [TW-1:0]    timer_q;
  logic             expire, last;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  assign expire = timer_q == TW'(TIMEOUT - 1);
  assign last   = id_q == IDW'(NREQ - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_done || expire) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= gidx;
          end
        end
        ISSUE: timer_q <= '0;
        WAIT: begin
          timer_q <= timer_q + 1'b1;
          // done beats a simultaneous expiry
          if (mul_done) begin
            p_q   <= mul_p;
            err_q <= 1'b0;
          end else if (expire) begin
            p_q   <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) ptr_q <= last ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // reset gating keeps ready low while held in reset
  assign req_ready = grant & {NREQ{state_q == IDLE && rst_n}};
  assign rsp_valid = state_q == RESP;
  assign mul_start = state_q == ISSUE;
  assign busy      = state_q != IDLE;
  assign rsp_id    = id_q;
  assign rsp_p     = p_q;
  assign rsp_err   = err_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Randomized bench for mult_scheduler with a
// transaction-level reference model.
module tb_mult_scheduler;

  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int TO   = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*N-1:0]    rsp_p;
  logic              rsp_err;
  logic              mul_start, mul_done;
  logic [N-1:0]      mul_a, mul_b;
  logic [2*N-1:0]    mul_p;
  logic              busy;

  always #5 clk = ~clk;

  mult_scheduler #(.NREQ(NREQ), .N(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // multiplier stub: lat cycles after start, 0 = never
  int lat = 1;
  bit spur = 0;
  int cnt = 0;
  logic [2*N-1:0] prod;

  always @(negedge rst_n) begin
    cnt = 0;
    mul_done = 1'b0;
  end

  always @(posedge clk) begin
    bit st;
    st = mul_start && rst_n;
    if (st) begin
      cnt = lat;
      prod = $signed(mul_a) * $signed(mul_b);
    end
    #2;
    mul_done = 1'b0;
    mul_p = {$urandom, $urandom};
    if (!rst_n) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_p = prod;
        end
      end
      if (spur) begin
        spur = 0;
        mul_done = 1'b1;
      end
    end
  end

  // requesters drop valid after being accepted
  logic [NREQ-1:0] rdy_seen = '0;
  bit rand_ready = 0;

  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~rdy_seen;
    rdy_seen = '0;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  end

  // reference model: one transaction at a time
  bit             m_busy = 0;
  int             m_ptr = 0, m_id = 0, m_acc = 0, m_rdy = 0;
  logic [N-1:0]   m_a, m_b;
  logic [2*N-1:0] m_p;
  bit             m_err;
  int             fires = 0;

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_ptr = 0;
    end else begin
      int g;
      if (!m_busy) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_busy = 1;
          m_id = g;
          m_a = req_a[g*N +: N];
          m_b = req_b[g*N +: N];
          m_acc = cyc;
          m_rdy = 1 << 30;
        end
      end else if (cyc == m_acc + 1) begin
        if (lat >= 1 && lat <= TO) begin
          m_rdy = cyc + 1 + lat;
          m_err = 0;
          m_p = $signed(m_a) * $signed(m_b);
        end else begin
          m_rdy = cyc + 1 + TO;
          m_err = 1;
          m_p = '0;
        end
      end else if (cyc >= m_rdy && rsp_ready) begin
        m_busy = 0;
        m_ptr = (m_id + 1) % NREQ;
        fires++;
      end
      cyc++;
    end
  end

  // observations of the DUT for hand-computed checks
  int order[$];
  int acc_cyc = 0, start_cyc = 0, rv_cyc = 0, fire_cyc = 0;
  int rv_rises = 0;
  bit rv_prev = 0;
  int last_id = 0;
  logic [63:0] last_p = '0;
  bit last_err = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g, c;
    c = cyc;
    if (!rst_n) begin
      chk("reset_ctl", {req_ready, rsp_valid, busy, mul_start,
                        rsp_err, rsp_id}, '0);
      chk("reset_ops", {mul_a, mul_b}, '0);
      chk("reset_p", rsp_p, '0);
    end else begin
      er = '0;
      if (!m_busy) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) er[g] = 1'b1;
      end
      chk("req_ready", req_ready, er);
      chk("busy", busy, m_busy);
      chk("mul_start", mul_start, m_busy && c == m_acc + 1);
      chk("rsp_valid", rsp_valid, m_busy && c >= m_rdy);
      if (m_busy && c >= m_rdy) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_p", rsp_p, m_p);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_busy) chk("mul_ops", {mul_a, mul_b}, {m_a, m_b});
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin
        order.push_back(i);
        acc_cyc = c;
      end
    rdy_seen = req_ready;
    if (mul_start) start_cyc = c;
    if (rsp_valid && !rv_prev) begin
      rv_cyc = c;
      rv_rises++;
    end
    rv_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      last_id = rsp_id;
      last_p = rsp_p;
      last_err = rsp_err;
      fire_cyc = c;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(int i, logic [N-1:0] a, logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_fires(int n, int budget);
    int t = 0;
    while (fires < n && t < budget) begin
      tick();
      t++;
    end
    chk("wait_fires", fires >= n, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base, r, t, saved;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    mul_done = 1'b0;
    mul_p = '0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", {busy, rsp_valid}, 0);

    // single request, L=32
    lat = 32;
    send(2, 7, -3);
    wait_fires(fires + 1, 100);
    chk("single_rsp_lat", rv_cyc - acc_cyc, 34);
    chk("single_start", start_cyc - acc_cyc, 1);
    chk("single_id", last_id, 2);
    chk("single_p", last_p, -64'sd21);
    chk("single_err", last_err, 0);

    // all four valid from reset, two rounds
    rst_n = 1'b0;
    lat = 3;
    for (int i = 0; i < NREQ; i++) send(i, i + 1, 10 * (i + 1));
    tick(2);
    rst_n = 1'b1;
    order.delete();
    wait_fires(fires + 4, 100);
    chk("rr1_n", order.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr1_order", order[k], k);
    order.delete();
    for (int i = 0; i < NREQ; i++) send(i, -i, 3);
    wait_fires(fires + 4, 100);
    chk("rr2_n", order.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr2_order", order[k], k);

    // backpressure with a spurious done in RESP
    lat = 5;
    rsp_ready = 1'b0;
    base = fires;
    send(1, 123, -456);
    t = 0;
    while (!rsp_valid && t < 50) begin
      tick();
      t++;
    end
    chk("bp_reach_resp", rsp_valid, 1);
    send(3, 9, 9);
    tick(4);
    spur = 1;
    tick(6);
    rsp_ready = 1'b1;
    wait_fires(base + 1, 20);
    chk("bp_p", last_p, -64'sd56088);
    chk("bp_id", last_id, 1);
    chk("bp_held", fire_cyc - rv_cyc >= 10, 1);
    wait_fires(base + 2, 60);
    chk("bp_next_p", last_p, 64'd81);

    // watchdog timeout, then normal service
    lat = 0;
    send(0, 5, 6);
    wait_fires(fires + 1, 100);
    chk("to_lat", rv_cyc - start_cyc, TO + 1);
    chk("to_err", last_err, 1);
    chk("to_p", last_p, 0);
    lat = 3;
    send(1, -8, 8);
    wait_fires(fires + 1, 40);
    chk("post_to_p", last_p, -64'sd64);
    chk("post_to_err", last_err, 0);

    // reset in WAIT
    lat = 20;
    send(3, 11, 12);
    tick(6);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_now", {busy, rsp_valid, mul_start}, 0);
    tick(2);
    rst_n = 1'b1;
    saved = rv_rises;
    tick(30);
    chk("no_rsp_after_rst", rv_rises, saved);
    lat = 2;
    send(1, 2, 3);
    send(3, 4, 5);
    wait_fires(fires + 1, 40);
    chk("ptr_after_rst", last_id, 1);
    wait_fires(fires + 1, 40);
    chk("ptr_after_rst2", last_id, 3);

    // operand extremes
    lat = 4;
    send(0, 32'h8000_0000, 32'h8000_0000);
    wait_fires(fires + 1, 40);
    chk("ext_min_min", last_p, 64'h4000_0000_0000_0000);
    send(1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    wait_fires(fires + 1, 40);
    chk("ext_m1_max", last_p, 64'hFFFF_FFFF_8000_0001);

    // randomized traffic
    rand_ready = 1;
    repeat (1500) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          send(i, $urandom, $urandom);
      r = $urandom_range(0, 19);
      lat = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1
          : $urandom_range(1, 12);
      tick();
    end
    rand_ready = 0;
    rsp_ready = 1'b1;
    lat = 3;
    t = 0;
    while ((busy || req_valid != '0) && t < 1000) begin
      tick();
      t++;
    end
    chk("drain", {busy, req_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Round-robin scheduler that shares one iterative signed multiplier (N-bit operands, 2N-bit product, start/done protocol, variable latency) among NREQ requesters. It accepts one request at a time over valid/ready and launches the shared multiplier. It returns the product with the requester ID on a single response channel and flags a watchdog timeout if the multiplier never signals done. It sits between client blocks and the multiplier core, so no client needs its own multiplier.

## Interface
- NREQ, 4, number of requesters (2..16); IDW = max(1, clog2(NREQ)) is derived, not settable
- N, 32, operand width; product width 2N
- TIMEOUT, 128, max cycles from mul_start to mul_done before error (≥ 2)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept strobe
- req_a  in  NREQ*N  packed operand A, requester i at [i*N +: N]
- req_b  in  NREQ*N  packed operand B, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester whose result is presented
- rsp_p  out  2N  signed product (0 on error)
- rsp_err  out  1  watchdog timeout occurred
- mul_start  out  1  one-cycle launch pulse to the multiplier
- mul_a, mul_b  out  N each  operands to the multiplier, stable from ISSUE through the end of WAIT
- mul_done  in  1  one-cycle completion pulse from the multiplier
- mul_p  in  2N  multiplier product, valid with mul_done
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is high, rr_arbiter picks the first valid index scanning upward from ptr, with wrap. req_ready[g] is high this cycle only, combinationally (state==IDLE & grant[g]). On the accept edge: capture req_a/req_b slice g into operand registers, capture g into id register, go to ISSUE.
- Requesters hold a/b stable while valid is high; valid may drop only after ready.
- ISSUE: mul_start=1 for exactly this cycle; clear timer; go to WAIT.
- WAIT: timer increments each cycle.
  - mul_done=1: capture mul_p into rsp_p, set rsp_err=0, go to RESP.
  - Otherwise, timer==TIMEOUT-1: set rsp_p=0, rsp_err=1, go to RESP.
  - mul_done wins if both happen in the same cycle.
- RESP: rsp_valid=1, and rsp_id/rsp_p/rsp_err stay stable until rsp_ready. On the fire edge: ptr ← (id+1) mod NREQ, go to IDLE.
- mul_done in IDLE, ISSUE or RESP is ignored. It must not alter rsp_p.
- At most one transaction is in flight. req_ready is all-zero outside IDLE.
- Widths: timer is clog2(TIMEOUT+1) bits. The product is passed through unmodified, with no sign handling in this block.

## Timing
- Reset (async assert, sync deassert is the top-level's job): state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0, busy=0, req_ready=0.
- Cycle 0: accept. Cycle 1: mul_start. Cycle 1+L: mul_done (L = multiplier latency, ≥1). Cycle 2+L: rsp_valid.
- After the rsp fire edge, IDLE is entered. The earliest next accept is the cycle after the fire cycle.
- Minimum request-to-request spacing is L+3 cycles, with rsp_ready held high.
- Timeout path: rsp_valid is asserted TIMEOUT+1 cycles after mul_start.
- Reset mid-operation (any state) aborts the transaction immediately. No response is produced. The multiplier must share rst_n.
- Fairness: a continuously valid requester waits at most NREQ-1 other transactions.

## Structure
- Package mult_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), a function computing IDW from NREQ, and a function computing timer width from TIMEOUT.
- Sub-module rr_arbiter (params NREQ; inputs req, ptr; output one-hot grant plus encoded index). It is purely combinational, so the pointer register stays in mult_scheduler.
- Top module holds the FSM, operand/id/result registers, timer, and ptr.

## Test plan
- Single request: requester 2 sends a=7, b=-3, with the multiplier model at L=32. Expect req_ready[2] in the accept cycle, mul_start one cycle later, then rsp_valid with rsp_id=2, rsp_p=-21, rsp_err=0, 34 cycles after accept.
- All four requesters valid from reset with distinct operands. Expect grant order 0,1,2,3. Then re-raise all four: order 0,1,2,3 again, since ptr wraps to 0.
- Backpressure: hold rsp_ready low for 10 cycles in RESP. Expect rsp_* stable, no new req_ready, and a spurious mul_done pulse that leaves rsp_p unchanged.
- Timeout: the multiplier model never pulses done, with TIMEOUT=8. Expect rsp_valid 9 cycles after mul_start with rsp_err=1 and rsp_p=0, then normal service of the next request.
- Reset mid-WAIT: deassert rst_n during WAIT. Expect all outputs at reset values immediately, no response after release, and the next request granted from ptr=0.
- Extremes with N=32: a=b=-2^31 → rsp_p=2^62; a=-1, b=2^31-1 → rsp_p=-(2^31-1), checked against the reference model.
